// File: rtl/mem_responder_if.sv
// Request/response channel between a load/store initiator and the data-memory responder.
// Addresses are full 32-bit word addresses; range checking happens in the responder.
interface mem_responder_if #(
    parameter int DATA_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [31:0]          req_addr;
    logic [DATA_SIZE-1:0] req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DATA_SIZE-1:0] resp_rdata;
    logic                 resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Data-memory responder: one outstanding word load/store, fixed latency, backpressured response.
//   state   | meaning
//   IDLE    | ready for a request
//   WAIT    | request latched, latency counter running
//   RESP    | response held until the initiator takes it
module mem_responder #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_SIZE     = 32,
    parameter int LATENCY       = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus,
    output logic           busy
);
    localparam int MEM_WORDS = 2 ** ADDRESS_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t               state, state_nxt;
    logic [3:0]           count;
    logic                 lat_write;
    logic [31:0]          lat_addr;
    logic [DATA_SIZE-1:0] lat_wdata;
    logic [DATA_SIZE-1:0] rdata_q;
    logic                 err_q;
    logic [DATA_SIZE-1:0] mem [MEM_WORDS];

    logic                 accept;
    logic                 enter_resp;
    logic                 op_write;
    logic [31:0]          op_addr;
    logic [DATA_SIZE-1:0] op_wdata;
    logic                 op_err;

    assign accept     = (state == ST_IDLE) && bus.req_valid;
    assign enter_resp = (state != ST_RESP) && (state_nxt == ST_RESP);

    // With LATENCY=1 the memory access happens on the accept edge itself, so use the live request.
    assign op_write = (state == ST_IDLE) ? bus.req_write : lat_write;
    assign op_addr  = (state == ST_IDLE) ? bus.req_addr  : lat_addr;
    assign op_wdata = (state == ST_IDLE) ? bus.req_wdata : lat_wdata;
    assign op_err   = (op_addr >= 32'(MEM_WORDS));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.req_valid) state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (count == 4'd1) state_nxt = ST_RESP;
            ST_RESP: if (bus.resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                lat_write <= bus.req_write;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                count     <= 4'(LATENCY - 1);
            end else if (state == ST_WAIT) begin
                count <= count - 4'd1;
            end
            if (enter_resp) begin
                if (op_err) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else if (op_write) begin
                    mem[op_addr[ADDRESS_WIDTH-1:0]] <= op_wdata;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end else begin
                    rdata_q <= mem[op_addr[ADDRESS_WIDTH-1:0]];
                    err_q   <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready  = (state == ST_IDLE);
        bus.resp_valid = (state == ST_RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        busy           = (state != ST_IDLE);
    end
endmodule
